// File: rtl/io_tx_fsm.sv
// ============================================================================
// io_tx_fsm
// ----------------------------------------------------------------------------
// Block-oriented word transmitter. Upstream pushes 32-bit words (four byte
// lanes plus a last flag) into a two-entry FIFO. A four-state FSM frames the
// buffered words into blocks for a downstream receiver. Each block is:
//   - an announce strobe carrying a mode qualifier,
//   - one or more ready/next word transfers,
//   - a single end-of-block strobe.
// A block ends after a word flagged last, or after MAX_WORDS transfers,
// whichever comes first.
//
// Parameters
//   MAX_WORDS  : words per block before eob is forced (2..4)
//   FIFO_DEPTH : input buffer entries (only 2 is supported)
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-low reset
//   load      in   upstream presents a word this cycle
//   lane1..4  in   byte lanes, packed into data[7:0] .. data[31:24]
//   last      in   loaded word closes its block
//   mode      in   value reported on proc during the announce cycle
//   load_ack  out  buffer can take a word this cycle
//   int_req   out  block announce strobe. This is the receiver's "int" line;
//                  it is renamed because int is a reserved word.
//   proc      out  block mode qualifier, valid while int_req=1. This is the
//                  receiver's "process" line, shortened to avoid the
//                  built-in process class name.
//   data      out  packed word to receiver; holds its value while ready=0
//   ready     out  data carries a valid, untransferred word
//   next      in   receiver accepts the word on data this cycle
//   eob       out  end-of-block strobe
// ============================================================================
module io_tx_fsm #(
    parameter int MAX_WORDS  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  lane1,
    input  logic [7:0]  lane2,
    input  logic [7:0]  lane3,
    input  logic [7:0]  lane4,
    input  logic        last,
    input  logic        mode,
    input  logic        next,
    output logic        load_ack,
    output logic        int_req,
    output logic        proc,
    output logic [31:0] data,
    output logic        ready,
    output logic        eob
);

    // The word counter must be able to hold MAX_WORDS itself, so its width
    // is 2 bits for MAX_WORDS of 2 or 3, and 3 bits for 4.
    localparam int              CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);
    localparam logic [1:0]       DEPTH   = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ANNOUNCE = 2'd1,
        S_SEND     = 2'd2,
        S_EOB      = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       occ;
    logic             rd_ptr, wr_ptr;
    logic [32:0]      mem [0:1];       // {last, packed word}
    logic [32:0]      head;
    logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
    logic [31:0]      data_hold;
    logic             push, pop;

    // load_ack looks only at registered occupancy. As a result, a full
    // buffer refuses a push even when a pop happens in the same cycle.
    assign load_ack = (occ < DEPTH);
    assign push     = load & load_ack;
    assign head     = mem[rd_ptr];

    // Next-state and strobe decode
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        int_req      = 1'b0;
        proc         = 1'b0;
        ready        = 1'b0;
        eob          = 1'b0;
        pop          = 1'b0;
        case (state)
            S_IDLE: begin
                if (occ != 2'd0) state_nxt = S_ANNOUNCE;
            end
            S_ANNOUNCE: begin
                int_req   = 1'b1;
                proc      = mode;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                ready = (occ != 2'd0);
                if (ready && next) begin
                    pop          = 1'b1;
                    word_cnt_nxt = word_cnt + 1'b1;
                    if (head[32] || (word_cnt_nxt == CNT_MAX)) state_nxt = S_EOB;
                end
            end
            S_EOB: begin
                eob          = 1'b1;
                word_cnt_nxt = '0;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // While no word is offered, data keeps showing the last value it drove.
    assign data = ready ? head[31:0] : data_hold;

    // Control state and the data hold register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            occ       <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            word_cnt  <= '0;
            data_hold <= 32'h0;
        end else begin
            state     <= state_nxt;
            word_cnt  <= word_cnt_nxt;
            data_hold <= data;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      occ <= occ + 2'd1;
            else if (pop && !push) occ <= occ - 2'd1;
        end
    end

    // FIFO storage needs no reset. Pointers and occupancy decide which
    // entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {last, lane4, lane3, lane2, lane1};
    end

endmodule

// File: tb/tb_io_tx_fsm.sv
module tb_io_tx_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        load, last, mode, next;
    logic [7:0]  lane1, lane2, lane3, lane4;
    logic        load_ack, int_req, proc, ready, eob;
    logic [31:0] data;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q[$];
    int xfer_cnt  = 0;
    int int_cnt   = 0;
    int eob_cnt   = 0;
    int blk_words = 0;
    int last_blk  = 0;

    always #5 clk = ~clk;

    io_tx_fsm #(.MAX_WORDS(4), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .load(load),
        .lane1(lane1), .lane2(lane2), .lane3(lane3), .lane4(lane4),
        .last(last), .mode(mode), .next(next),
        .load_ack(load_ack), .int_req(int_req), .proc(proc),
        .data(data), .ready(ready), .eob(eob)
    );

    // Scoreboard monitor: pops the expected word on every transfer and
    // tracks strobes and the block size.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (reset === 1'b1) begin
            tests_run++;
            if ((int'(int_req) + int'(eob) + int'(ready)) > 1) begin
                tests_failed++;
                $display("FAIL strobe_exclusive int=%0b eob=%0b ready=%0b (want at most one)", int_req, eob, ready);
            end
            if (int_req === 1'b1) begin
                int_cnt++;
                blk_words = 0;
                tests_run++;
                if (proc !== mode) begin
                    tests_failed++;
                    $display("FAIL announce_proc got %0b want %0b", proc, mode);
                end
            end
            if (ready === 1'b1 && next === 1'b1) begin
                xfer_cnt++;
                blk_words++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_word got %h want none", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        tests_failed++;
                        $display("FAIL word_order got %h want %h", data, e);
                    end
                end
            end
            if (eob === 1'b1) begin
                eob_cnt++;
                last_blk = blk_words;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] w, input logic l);
        int g = 0;
        {lane4, lane3, lane2, lane1} = w;
        last = l;
        load = 1'b1;
        while (load_ack !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        tests_run++;
        if (g >= 50) begin
            tests_failed++;
            $display("FAIL put_word_timeout load_ack=%0b want 1", load_ack);
        end else begin
            exp_q.push_back(w);
        end
        tick();
        load = 1'b0;
        last = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            tick();
            g++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic wait_ready();
        int g = 0;
        while (ready !== 1'b1 && g < 20) begin
            tick();
            g++;
        end
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_timeout ready=%0b want 1", ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 0; last = 0; mode = 0; next = 0;
        {lane4, lane3, lane2, lane1} = 32'h0;
        #3;
        tests_run++;
        if ({int_req, proc, eob, ready, load_ack} !== 5'b00001 || data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got int/proc/eob/ready/ack=%b data=%h want 00001 00000000",
                     {int_req, proc, eob, ready, load_ack}, data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick();
        tests_run++;
        if ({int_req, eob, ready, load_ack} !== 4'b0001 || data !== 32'h0) begin
            tests_failed++;
            $display("FAIL after_reset got int/eob/ready/ack=%b data=%h want 0001 00000000",
                     {int_req, eob, ready, load_ack}, data);
        end
    endtask

    task automatic test_single();
        mode = 1'b1;
        next = 1'b1;
        put_word(32'h44332211, 1'b1);
        tests_run++;
        if (int_req !== 1'b0 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle got int=%0b ready=%0b want 0 0", int_req, ready);
        end
        tick();
        tests_run++;
        if (int_req !== 1'b1 || proc !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_announce got int=%0b proc=%0b want 1 1", int_req, proc);
        end
        tick();
        tests_run++;
        if (ready !== 1'b1 || data !== 32'h44332211) begin
            tests_failed++;
            $display("FAIL single_send got ready=%0b data=%h want 1 44332211", ready, data);
        end
        tick();
        tests_run++;
        if (eob !== 1'b1 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_eob got eob=%0b ready=%0b want 1 0", eob, ready);
        end
        tick();
        tests_run++;
        if ({int_req, eob, ready} !== 3'b000 || data !== 32'h44332211) begin
            tests_failed++;
            $display("FAIL single_idle_after got int/eob/ready=%b data=%h want 000 44332211",
                     {int_req, eob, ready}, data);
        end
        next = 1'b0;
        mode = 1'b0;
    endtask

    task automatic test_max_words();
        int i0 = int_cnt;
        int e0 = eob_cnt;
        int x0 = xfer_cnt;
        mode = 1'b0;
        next = 1'b1;
        for (int i = 0; i < 5; i++) put_word(32'hA000_0000 + i, 1'b0);
        wait_drain();
        repeat (3) tick();
        tests_run++;
        if (xfer_cnt - x0 != 5 || eob_cnt - e0 != 1 || int_cnt - i0 != 2 || last_blk != 4) begin
            tests_failed++;
            $display("FAIL max_words got xfer=%0d eob=%0d int=%0d blk=%0d want 5 1 2 4",
                     xfer_cnt - x0, eob_cnt - e0, int_cnt - i0, last_blk);
        end
        put_word(32'hA5A5_A5A5, 1'b1);
        wait_drain();
        repeat (3) tick();
        tests_run++;
        if (eob_cnt - e0 != 2 || last_blk != 2) begin
            tests_failed++;
            $display("FAIL max_words_tail got eob=%0d blk=%0d want 2 2", eob_cnt - e0, last_blk);
        end
        next = 1'b0;
    endtask

    task automatic test_fill_drop();
        int x0 = xfer_cnt;
        int e0 = eob_cnt;
        next = 1'b0;
        put_word(32'h1111_0001, 1'b0);
        put_word(32'h1111_0002, 1'b1);
        tests_run++;
        if (load_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_ack got %0b want 0", load_ack);
        end
        {lane4, lane3, lane2, lane1} = 32'hDEAD_BEEF;
        last = 1'b1;
        load = 1'b1;
        tick();
        tests_run++;
        if (load_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_ack_hold got %0b want 0", load_ack);
        end
        tick();
        load = 1'b0;
        last = 1'b0;
        next = 1'b1;
        wait_drain();
        repeat (4) tick();
        tests_run++;
        if (xfer_cnt - x0 != 2 || eob_cnt - e0 != 1 || last_blk != 2) begin
            tests_failed++;
            $display("FAIL fill_drop got xfer=%0d eob=%0d blk=%0d want 2 1 2",
                     xfer_cnt - x0, eob_cnt - e0, last_blk);
        end
        next = 1'b0;
    endtask

    task automatic test_simul();
        next = 1'b0;
        put_word(32'h2222_0001, 1'b0);
        wait_ready();
        tests_run++;
        if (load_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_pre_ack got %0b want 1", load_ack);
        end
        {lane4, lane3, lane2, lane1} = 32'h2222_0002;
        last = 1'b1;
        load = 1'b1;
        next = 1'b1;
        exp_q.push_back(32'h2222_0002);
        tick();
        load = 1'b0;
        last = 1'b0;
        tests_run++;
        if (load_ack !== 1'b1 || ready !== 1'b1 || data !== 32'h2222_0002) begin
            tests_failed++;
            $display("FAIL simul_occ got ack=%0b ready=%0b data=%h want 1 1 22220002", load_ack, ready, data);
        end
        tick();
        tests_run++;
        if (eob !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_eob got %0b want 1", eob);
        end
        next = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int e0, x0, i0;
        next = 1'b0;
        put_word(32'h3333_0001, 1'b0);
        put_word(32'h3333_0002, 1'b0);
        wait_ready();
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({int_req, proc, eob, ready, load_ack} !== 5'b00001 || data !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_outputs got int/proc/eob/ready/ack=%b data=%h want 00001 00000000",
                     {int_req, proc, eob, ready, load_ack}, data);
        end
        exp_q.delete();
        e0 = eob_cnt;
        x0 = xfer_cnt;
        i0 = int_cnt;
        @(negedge clk);
        reset = 1'b1;
        next = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (eob_cnt != e0 || xfer_cnt != x0 || int_cnt != i0 || ready !== 1'b0 || data !== 32'h0) begin
            tests_failed++;
            $display("FAIL midreset_after got eob=%0d xfer=%0d int=%0d ready=%0b data=%h want 0 0 0 0 00000000",
                     eob_cnt - e0, xfer_cnt - x0, int_cnt - i0, ready, data);
        end
        next = 1'b0;
    endtask

    task automatic test_next_ignored();
        int x0 = xfer_cnt;
        next = 1'b0;
        put_word(32'h4444_0001, 1'b1);
        next = 1'b1;
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL nign_idle got ready=%0b want 0", ready);
        end
        tick();
        tests_run++;
        if (int_req !== 1'b1 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL nign_announce got int=%0b ready=%0b want 1 0", int_req, ready);
        end
        next = 1'b0;
        tick();
        tests_run++;
        if (ready !== 1'b1 || data !== 32'h4444_0001) begin
            tests_failed++;
            $display("FAIL nign_send got ready=%0b data=%h want 1 44440001", ready, data);
        end
        tick();
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL nign_wait got ready=%0b want 1", ready);
        end
        next = 1'b1;
        tick();
        tests_run++;
        if (eob !== 1'b1) begin
            tests_failed++;
            $display("FAIL nign_eob got %0b want 1", eob);
        end
        next = 1'b0;
        tick();
        next = 1'b1;
        tick();
        tests_run++;
        if (xfer_cnt - x0 != 1 || ready !== 1'b0 || int_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL nign_count got xfer=%0d ready=%0b int=%0b want 1 0 0",
                     xfer_cnt - x0, ready, int_req);
        end
        for (int i = 0; i < 4; i++) put_word(32'h5555_0000 + i, 1'b0);
        wait_drain();
        repeat (3) tick();
        tests_run++;
        if (last_blk != 4) begin
            tests_failed++;
            $display("FAIL nign_wordcnt got blk=%0d want 4", last_blk);
        end
        next = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_max_words();
        test_fill_drop();
        test_simul();
        test_reset_mid();
        test_next_ignored();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/io_tx_fsm.md
IO_TX_FSM -- requirements
Module: io_tx_fsm

Interface
REQ-001 Parameter MAX_WORDS, default 4, meaning: maximum words per block before eob is forced (2..4).
REQ-002 Parameter FIFO_DEPTH, default 2, meaning: input buffer entries (fixed at 2; no other value supported).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 load  in  1  upstream presents a word on lane1..lane4/last this cycle.
REQ-006 lane1, lane2, lane3, lane4  in  8 each  byte lanes; packed as data[7:0], [15:8], [23:16], [31:24].
REQ-007 last  in  1  loaded word is the final word of its block.
REQ-008 mode  in  1  value driven on process during announce.
REQ-009 load_ack  out  1  buffer can accept a word this cycle.
REQ-010 int  out  1  block announce strobe to receiver.
REQ-011 process  out  1  block mode qualifier, valid while int=1.
REQ-012 data  out  32  packed word to receiver.
REQ-013 ready  out  1  data holds a valid, untransferred word.
REQ-014 next  in  1  receiver accepts the word on data this cycle.
REQ-015 eob  out  1  end-of-block strobe.

Function
REQ-016 load_ack SHALL equal (buffer occupancy < 2), computed from registered occupancy only.
REQ-017 A push SHALL occur on a cycle with load=1 and load_ack=1; load while load_ack=0 SHALL be ignored (word dropped, no state change).
REQ-018 Buffer SHALL be FIFO-ordered; each entry stores 32 packed bits plus last.
REQ-019 States SHALL be IDLE, ANNOUNCE, SEND, EOB, encoded in a 2-bit state register.
REQ-020 IDLE: all strobes 0; go to ANNOUNCE on the cycle after occupancy becomes non-zero.
REQ-021 ANNOUNCE: exactly one cycle with int=1 and process=mode (sampled that cycle); then SEND.
REQ-022 SEND: ready=1 iff occupancy>0; data=FIFO head while ready=1.
REQ-023 Transfer SHALL occur on a cycle with state=SEND, ready=1, next=1: pop head, word_cnt increments.
REQ-024 next while ready=0 or outside SEND SHALL be ignored.
REQ-025 After a transfer whose word had last=1, or that made word_cnt equal MAX_WORDS, go to EOB; else stay in SEND.
REQ-026 EOB: exactly one cycle with eob=1, word_cnt cleared to 0; then IDLE.
REQ-027 word_cnt SHALL be 2 bits (3 bits if MAX_WORDS=4 requires reaching 4 -- implementer sizes to hold MAX_WORDS), never wraps within a block.
REQ-028 Simultaneous push and pop: both SHALL take effect; occupancy unchanged.
REQ-029 Push with occupancy=2 SHALL be refused even if a pop occurs the same cycle.
REQ-030 When ready=0, data SHALL hold its last driven value (registered output).
REQ-031 Latency: word loaded into empty buffer while IDLE reaches ready=1 three cycles later (IDLE->ANNOUNCE->SEND).
REQ-032 int, eob and ready SHALL be mutually exclusive in every cycle.
REQ-033 SEND with empty buffer SHALL wait indefinitely (no timeout) with ready=0.

Reset
REQ-034 reset=0 SHALL immediately force state=IDLE, occupancy=0, word_cnt=0.
REQ-035 During and after reset: int=0, process=0, eob=0, ready=0, data=32'h0, load_ack=1.
REQ-036 Reset mid-block SHALL discard buffered words; no eob is emitted for the aborted block.

Verification
REQ-037 Load one word lanes 11,22,33,44 with last=1, next held 1 -> int pulse, then data=32'h44332211 with ready=1 for one cycle, then eob pulse, back to IDLE.
REQ-038 Load 5 words, last=0, MAX_WORDS=4, next=1 -> 4 transfers, eob, new int, 5th word transferred in second block.
REQ-039 Fill buffer (2 words), next=0, third load -> load_ack=0, third word dropped; release next -> only the 2 words appear in order.
REQ-040 Occupancy 1, load and transfer same cycle -> occupancy stays 1, load_ack stays 1, order preserved.
REQ-041 Assert reset=0 during SEND with 2 words buffered -> outputs reach reset values asynchronously; after release, no eob and no stale data appear.
REQ-042 next toggling while IDLE/ANNOUNCE/EOB -> no pops, word_cnt unchanged.
